alu_issue: RTL and testbench



---
 rtl/alu_issue_pkg.sv | 35 +++
 rtl/alu_issue_decode.sv | 47 ++++
 rtl/alu_issue.sv | 208 ++++++++++++++++++++
 tb/tb_alu_issue.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants for the ALU issue/capture front end.
//   - function codes presented on InFunct (FUNCT_*)
//   - ALU operation encodings driven onto AluOp (ALUOP_*)
//   - FSM state encoding (IDLE / EXEC / DONE)
package alu_issue_pkg;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 4;

  localparam logic [3:0] FUNCT_AND = 4'b0000;
  localparam logic [3:0] FUNCT_OR  = 4'b0001;
  localparam logic [3:0] FUNCT_ADD = 4'b0010;
  localparam logic [3:0] FUNCT_SUB = 4'b0011;
  localparam logic [3:0] FUNCT_SLT = 4'b0100;
  localparam logic [3:0] FUNCT_XOR = 4'b0101;
  localparam logic [3:0] FUNCT_NOR = 4'b0110;
  localparam logic [3:0] FUNCT_SLL = 4'b0111;
  localparam logic [3:0] FUNCT_SRA = 4'b1000;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SLT = 3'b011;
  localparam logic [2:0] ALUOP_XOR = 3'b100;
  localparam logic [2:0] ALUOP_NOR = 3'b101;
  localparam logic [2:0] ALUOP_SLL = 3'b110;
  localparam logic [2:0] ALUOP_SRA = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational function-code decoder.
// Ports:
//   funct    in  4 : function code from the request
//   op       out 3 : ALU operation
//   bnegate  out 1 : B-invert / carry-in (SUB and SLT)
//   illegal  out 1 : function code 1001..1111
//   arith    out 1 : ADD or SUB; only these report overflow/carry
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [3:0] funct,
  output logic [2:0] op,
  output logic       bnegate,
  output logic       illegal,
  output logic       arith
);

  always_comb begin
    op      = ALUOP_AND;
    bnegate = 1'b0;
    illegal = 1'b0;
    arith   = 1'b0;
    case (funct)
      FUNCT_AND: op = ALUOP_AND;
      FUNCT_OR:  op = ALUOP_OR;
      FUNCT_ADD: begin
        op    = ALUOP_ADD;
        arith = 1'b1;
      end
      FUNCT_SUB: begin
        op      = ALUOP_ADD;
        bnegate = 1'b1;
        arith   = 1'b1;
      end
      FUNCT_SLT: begin
        op      = ALUOP_SLT;
        bnegate = 1'b1;
      end
      FUNCT_XOR: op = ALUOP_XOR;
      FUNCT_NOR: op = ALUOP_NOR;
      FUNCT_SLL: op = ALUOP_SLL;
      FUNCT_SRA: op = ALUOP_SRA;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: sequential issue/capture front end for the 16-bit combinational ALU.
// Accepts a request (InValid/InReady), registers decoded controls and operands
// onto the Alu* outputs, captures the ALU result one cycle later and returns it
// over OutValid/OutReady. FSM: IDLE -> EXEC -> DONE -> IDLE (illegal codes go
// IDLE -> DONE directly and leave the Alu* outputs untouched).
// Ports:
//   Clock, Reset (synchronous, active-high)
//   InValid/InReady, InFunct[3:0], InA[15:0], InB[15:0], InShamt[3:0] : request
//   AluA, AluB, AluBNegate, AluOp[2:0], AluShamt[3:0]                  : to ALU
//   AluResult[15:0], AluOverflow, AluCarryOut                          : from ALU
//   OutValid/OutReady, OutResult, OutZero, OutOverflow, OutCarry,
//   OutIllegal                                                         : response
// Optional feature macro ALU_ISSUE_STICKY_EN adds StickyOverflow, StickyCarry
// (outputs) and FlagsClear (input): sticky flags set on any captured response
// with the flag high, cleared by Reset or FlagsClear (set wins over clear).
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [3:0]  InFunct,
  input  logic [15:0] InA,
  input  logic [15:0] InB,
  input  logic [3:0]  InShamt,
  output logic [15:0] AluA,
  output logic [15:0] AluB,
  output logic        AluBNegate,
  output logic [2:0]  AluOp,
  output logic [3:0]  AluShamt,
  input  logic [15:0] AluResult,
  input  logic        AluOverflow,
  input  logic        AluCarryOut,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [15:0] OutResult,
  output logic        OutZero,
  output logic        OutOverflow,
  output logic        OutCarry,
`ifdef ALU_ISSUE_STICKY_EN
  output logic        StickyOverflow,
  output logic        StickyCarry,
  input  logic        FlagsClear,
`endif
  output logic        OutIllegal
);

  logic [2:0] dec_op;
  logic       dec_bnegate;
  logic       dec_illegal;
  logic       dec_arith;

  alu_issue_decode u_decode (
    .funct   (InFunct),
    .op      (dec_op),
    .bnegate (dec_bnegate),
    .illegal (dec_illegal),
    .arith   (dec_arith)
  );

  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic        alu_bnegate_q, alu_bnegate_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [3:0]  alu_shamt_q, alu_shamt_d;
  // Remembers whether the in-flight op is ADD/SUB so flags can be masked.
  logic        arith_q, arith_d;
  logic [15:0] out_result_q, out_result_d;
  logic        out_zero_q, out_zero_d;
  logic        out_overflow_q, out_overflow_d;
  logic        out_carry_q, out_carry_d;
  logic        out_illegal_q, out_illegal_d;

  always_comb begin
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_bnegate_d  = alu_bnegate_q;
    alu_op_d       = alu_op_q;
    alu_shamt_d    = alu_shamt_q;
    arith_d        = arith_q;
    out_result_d   = out_result_q;
    out_zero_d     = out_zero_q;
    out_overflow_d = out_overflow_q;
    out_carry_d    = out_carry_q;
    out_illegal_d  = out_illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (InValid) begin
          if (!dec_illegal) begin
            alu_a_d       = InA;
            alu_b_d       = InB;
            alu_bnegate_d = dec_bnegate;
            alu_op_d      = dec_op;
            alu_shamt_d   = InShamt;
            arith_d       = dec_arith;
            state_d       = ST_EXEC;
          end else begin
            // Illegal: answer immediately, ALU controls untouched.
            out_result_d   = 16'h0000;
            out_zero_d     = 1'b0;
            out_overflow_d = 1'b0;
            out_carry_d    = 1'b0;
            out_illegal_d  = 1'b1;
            state_d        = ST_DONE;
          end
        end
      end
      ST_EXEC: begin
        // Zero is derived here rather than taken from the ALU so it is
        // meaningful for shift results as well.
        out_result_d   = AluResult;
        out_zero_d     = (AluResult == 16'h0000);
        out_overflow_d = arith_q & AluOverflow;
        out_carry_d    = arith_q & AluCarryOut;
        out_illegal_d  = 1'b0;
        state_d        = ST_DONE;
      end
      ST_DONE: begin
        if (OutReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs are registered from the next state.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      alu_a_q        <= 16'h0000;
      alu_b_q        <= 16'h0000;
      alu_bnegate_q  <= 1'b0;
      alu_op_q       <= 3'b000;
      alu_shamt_q    <= 4'h0;
      arith_q        <= 1'b0;
      out_result_q   <= 16'h0000;
      out_zero_q     <= 1'b0;
      out_overflow_q <= 1'b0;
      out_carry_q    <= 1'b0;
      out_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_bnegate_q  <= alu_bnegate_d;
      alu_op_q       <= alu_op_d;
      alu_shamt_q    <= alu_shamt_d;
      arith_q        <= arith_d;
      out_result_q   <= out_result_d;
      out_zero_q     <= out_zero_d;
      out_overflow_q <= out_overflow_d;
      out_carry_q    <= out_carry_d;
      out_illegal_q  <= out_illegal_d;
    end
  end

`ifdef ALU_ISSUE_STICKY_EN
  logic sticky_overflow_q, sticky_overflow_d;
  logic sticky_carry_q, sticky_carry_d;

  always_comb begin
    sticky_overflow_d = FlagsClear ? 1'b0 : sticky_overflow_q;
    sticky_carry_d    = FlagsClear ? 1'b0 : sticky_carry_q;
    // A capture with the flag high overrides a simultaneous clear.
    if (state_q == ST_EXEC && arith_q && AluOverflow) sticky_overflow_d = 1'b1;
    if (state_q == ST_EXEC && arith_q && AluCarryOut) sticky_carry_d    = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sticky_overflow_q <= 1'b0;
      sticky_carry_q    <= 1'b0;
    end else begin
      sticky_overflow_q <= sticky_overflow_d;
      sticky_carry_q    <= sticky_carry_d;
    end
  end

  assign StickyOverflow = sticky_overflow_q;
  assign StickyCarry    = sticky_carry_q;
`endif

  assign InReady     = in_ready_q;
  assign OutValid    = out_valid_q;
  assign AluA        = alu_a_q;
  assign AluB        = alu_b_q;
  assign AluBNegate  = alu_bnegate_q;
  assign AluOp       = alu_op_q;
  assign AluShamt    = alu_shamt_q;
  assign OutResult   = out_result_q;
  assign OutZero     = out_zero_q;
  assign OutOverflow = out_overflow_q;
  assign OutCarry    = out_carry_q;
  assign OutIllegal  = out_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue. A small behavioural
// 16-bit ALU closes the loop from the Alu* outputs to AluResult/flags; its
// adder flags are computed for every op so that masking of non-arith flags
// is observable.
module tb_alu_issue;

  logic        Clock;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [3:0]  InFunct;
  logic [15:0] InA;
  logic [15:0] InB;
  logic [3:0]  InShamt;
  logic [15:0] AluA;
  logic [15:0] AluB;
  logic        AluBNegate;
  logic [2:0]  AluOp;
  logic [3:0]  AluShamt;
  logic [15:0] AluResult;
  logic        AluOverflow;
  logic        AluCarryOut;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] OutResult;
  logic        OutZero;
  logic        OutOverflow;
  logic        OutCarry;
  logic        OutIllegal;
`ifdef ALU_ISSUE_STICKY_EN
  logic        StickyOverflow;
  logic        StickyCarry;
  logic        FlagsClear;
`endif

  int vectors;
  int miscompares;

  alu_issue dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .InValid     (InValid),
    .InReady     (InReady),
    .InFunct     (InFunct),
    .InA         (InA),
    .InB         (InB),
    .InShamt     (InShamt),
    .AluA        (AluA),
    .AluB        (AluB),
    .AluBNegate  (AluBNegate),
    .AluOp       (AluOp),
    .AluShamt    (AluShamt),
    .AluResult   (AluResult),
    .AluOverflow (AluOverflow),
    .AluCarryOut (AluCarryOut),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .OutResult   (OutResult),
    .OutZero     (OutZero),
    .OutOverflow (OutOverflow),
    .OutCarry    (OutCarry),
`ifdef ALU_ISSUE_STICKY_EN
    .StickyOverflow (StickyOverflow),
    .StickyCarry    (StickyCarry),
    .FlagsClear     (FlagsClear),
`endif
    .OutIllegal  (OutIllegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Behavioural ALU
  logic [15:0] bx;
  logic [16:0] sum;
  always_comb begin
    bx          = AluBNegate ? ~AluB : AluB;
    sum         = {1'b0, AluA} + {1'b0, bx} + {16'b0, AluBNegate};
    AluCarryOut = sum[16];
    AluOverflow = (AluA[15] == bx[15]) && (sum[15] != AluA[15]);
    case (AluOp)
      3'b000:  AluResult = AluA & AluB;
      3'b001:  AluResult = AluA | AluB;
      3'b010:  AluResult = sum[15:0];
      3'b011:  AluResult = {15'b0, ($signed(AluA) < $signed(AluB))};
      3'b100:  AluResult = AluA ^ AluB;
      3'b101:  AluResult = ~(AluA | AluB);
      3'b110:  AluResult = AluA << AluShamt;
      default: AluResult = $unsigned($signed(AluA) >>> AluShamt);
    endcase
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One legal transaction with OutReady asserted once the response appears.
  task automatic do_txn(input string name, input logic [3:0] f,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] sh, input logic [2:0] exp_op,
                        input logic exp_bn, input logic [15:0] exp_res,
                        input logic exp_z, input logic exp_o, input logic exp_c);
    InValid = 1'b1; InFunct = f; InA = a; InB = b; InShamt = sh;
    vectors++;
    if (InReady !== 1'b1) begin
      miscompares++; $display("FAIL %s_inready_pre: got %b want 1", name, InReady);
    end
    tick();  // accept edge
    InValid = 1'b0;
    vectors++;
    if ({OutValid, InReady} !== 2'b00) begin
      miscompares++; $display("FAIL %s_exec_hs: got %b want 00", name, {OutValid, InReady});
    end
    vectors++;
    if ({AluOp, AluBNegate} !== {exp_op, exp_bn}) begin
      miscompares++; $display("FAIL %s_ctrl: got %b want %b", name, {AluOp, AluBNegate}, {exp_op, exp_bn});
    end
    tick();  // capture edge
    vectors++;
    if ({OutValid, InReady, OutIllegal} !== 3'b100) begin
      miscompares++; $display("FAIL %s_done_hs: got %b want 100", name, {OutValid, InReady, OutIllegal});
    end
    vectors++;
    if (OutResult !== exp_res) begin
      miscompares++; $display("FAIL %s_result: got %h want %h", name, OutResult, exp_res);
    end
    vectors++;
    if ({OutZero, OutOverflow, OutCarry} !== {exp_z, exp_o, exp_c}) begin
      miscompares++; $display("FAIL %s_flags(zoc): got %b want %b", name, {OutZero, OutOverflow, OutCarry}, {exp_z, exp_o, exp_c});
    end
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    vectors++;
    if ({OutValid, InReady} !== 2'b01) begin
      miscompares++; $display("FAIL %s_release: got %b want 01", name, {OutValid, InReady});
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    vectors++;
    if ({InReady, OutValid} !== 2'b10) begin
      miscompares++; $display("FAIL reset_hs: got %b want 10", {InReady, OutValid});
    end
    vectors++;
    if ({OutResult, OutZero, OutOverflow, OutCarry, OutIllegal} !== 20'h0) begin
      miscompares++; $display("FAIL reset_out: got %h want 0", {OutResult, OutZero, OutOverflow, OutCarry, OutIllegal});
    end
    vectors++;
    if ({AluA, AluB, AluOp, AluShamt, AluBNegate} !== 40'h0) begin
      miscompares++; $display("FAIL reset_alu: got %h want 0", {AluA, AluB, AluOp, AluShamt, AluBNegate});
    end
  endtask

  task automatic test_arith();
    do_txn("add_ovf", 4'b0010, 16'h7FFF, 16'h0001, 4'h0, 3'b010, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_txn("sub_eq",  4'b0011, 16'h0005, 16'h0005, 4'h0, 3'b010, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_logic();
    do_txn("slt",  4'b0100, 16'hFFFF, 16'h0001, 4'h0, 3'b011, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_txn("xor",  4'b0101, 16'h00FF, 16'h0F0F, 4'h0, 3'b100, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0);
    do_txn("nor",  4'b0110, 16'h0000, 16'h0000, 4'h0, 3'b101, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_shift();
    // B chosen so the ALU adder raises carry/overflow, which must be masked.
    do_txn("sll", 4'b0111, 16'h0001, 16'hFFFF, 4'hF, 3'b110, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);
    do_txn("sra", 4'b1000, 16'h8000, 16'h8000, 4'h4, 3'b111, 1'b0, 16'hF800, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    // Follows SRA of 0x8000: Alu* must remain as left by that op.
    InValid = 1'b1; InFunct = 4'b1010; InA = 16'h1234; InB = 16'h5678; InShamt = 4'h3;
    tick();
    InValid = 1'b0;
    vectors++;
    if ({OutValid, InReady, OutIllegal} !== 3'b101) begin
      miscompares++; $display("FAIL illegal_hs: got %b want 101", {OutValid, InReady, OutIllegal});
    end
    vectors++;
    if ({OutResult, OutZero, OutOverflow, OutCarry} !== 19'h0) begin
      miscompares++; $display("FAIL illegal_out: got %h want 0", {OutResult, OutZero, OutOverflow, OutCarry});
    end
    vectors++;
    if ({AluOp, AluA, AluShamt} !== {3'b111, 16'h8000, 4'h4}) begin
      miscompares++; $display("FAIL illegal_alu_held: got %h want %h", {AluOp, AluA, AluShamt}, {3'b111, 16'h8000, 4'h4});
    end
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    vectors++;
    if ({OutValid, InReady} !== 2'b01) begin
      miscompares++; $display("FAIL illegal_release: got %b want 01", {OutValid, InReady});
    end
  endtask

  task automatic test_backpressure();
    InValid = 1'b1; InFunct = 4'b0010; InA = 16'h0003; InB = 16'h0004; InShamt = 4'h0;
    tick(); tick();
    // Held follow-up request: AND 0xF0F0 & 0xFF00
    InFunct = 4'b0000; InA = 16'hF0F0; InB = 16'hFF00;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({OutValid, InReady, OutResult, AluOp} !== {2'b10, 16'h0007, 3'b010}) begin
        miscompares++; $display("FAIL bp_hold%0d: got %h want %h", i, {OutValid, InReady, OutResult, AluOp}, {2'b10, 16'h0007, 3'b010});
      end
      tick();
    end
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    vectors++;
    if ({OutValid, InReady, AluOp} !== {2'b01, 3'b010}) begin
      miscompares++; $display("FAIL bp_release: got %b want 01010", {OutValid, InReady, AluOp});
    end
    tick();
    InValid = 1'b0;
    vectors++;
    if ({AluOp, AluA} !== {3'b000, 16'hF0F0}) begin
      miscompares++; $display("FAIL bp_accept: got %h want %h", {AluOp, AluA}, {3'b000, 16'hF0F0});
    end
    tick();
    vectors++;
    if ({OutValid, OutResult} !== {1'b1, 16'hF000}) begin
      miscompares++; $display("FAIL bp_result: got %h want %h", {OutValid, OutResult}, {1'b1, 16'hF000});
    end
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
  endtask

  task automatic test_reset_exec();
    InValid = 1'b1; InFunct = 4'b0010; InA = 16'h0001; InB = 16'h0001; InShamt = 4'h0;
    tick();
    InValid = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    vectors++;
    if ({OutValid, InReady} !== 2'b01) begin
      miscompares++; $display("FAIL rst_exec_hs: got %b want 01", {OutValid, InReady});
    end
    tick();
    vectors++;
    if ({OutValid, InReady} !== 2'b01) begin
      miscompares++; $display("FAIL rst_exec_noresp: got %b want 01", {OutValid, InReady});
    end
  endtask

  task automatic test_back_to_back();
    OutReady = 1'b1;
    InValid = 1'b1; InFunct = 4'b0010; InA = 16'h0001; InB = 16'h0001; InShamt = 4'h0;
    tick();  // accept
    vectors++;
    if ({OutValid, InReady} !== 2'b00) begin
      miscompares++; $display("FAIL b2b_exec: got %b want 00", {OutValid, InReady});
    end
    tick();  // capture
    vectors++;
    if ({OutValid, InReady, OutResult} !== {2'b10, 16'h0002}) begin
      miscompares++; $display("FAIL b2b_done: got %h want %h", {OutValid, InReady, OutResult}, {2'b10, 16'h0002});
    end
    tick();  // handshake
    vectors++;
    if ({OutValid, InReady} !== 2'b01) begin
      miscompares++; $display("FAIL b2b_idle: got %b want 01", {OutValid, InReady});
    end
    InA = 16'h0002;
    tick();  // second accept
    InValid = 1'b0;
    vectors++;
    if ({InReady, AluA} !== {1'b0, 16'h0002}) begin
      miscompares++; $display("FAIL b2b_accept2: got %h want %h", {InReady, AluA}, {1'b0, 16'h0002});
    end
    tick(); tick();
    OutReady = 1'b0;
  endtask

`ifdef ALU_ISSUE_STICKY_EN
  task automatic test_sticky();
    vectors++;
    if ({StickyOverflow, StickyCarry} !== 2'b00) begin
      miscompares++; $display("FAIL sticky_init: got %b want 00", {StickyOverflow, StickyCarry});
    end
    do_txn("sticky_add", 4'b0010, 16'h7FFF, 16'h0001, 4'h0, 3'b010, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    vectors++;
    if ({StickyOverflow, StickyCarry} !== 2'b10) begin
      miscompares++; $display("FAIL sticky_set: got %b want 10", {StickyOverflow, StickyCarry});
    end
    FlagsClear = 1'b1;
    tick();
    FlagsClear = 1'b0;
    vectors++;
    if ({StickyOverflow, StickyCarry} !== 2'b00) begin
      miscompares++; $display("FAIL sticky_clear: got %b want 00", {StickyOverflow, StickyCarry});
    end
  endtask
`endif

  initial begin
    vectors = 0; miscompares = 0;
    Reset = 1'b1; InValid = 1'b0; InFunct = 4'h0; InA = 16'h0; InB = 16'h0;
    InShamt = 4'h0; OutReady = 1'b0;
`ifdef ALU_ISSUE_STICKY_EN
    FlagsClear = 1'b0;
`endif
    test_reset();
`ifdef ALU_ISSUE_STICKY_EN
    test_sticky();
`endif
    test_arith();
    test_logic();
    test_shift();
    test_illegal();
    test_backpressure();
    test_reset_exec();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
